// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: operand fetch with writeback bypass, load-use bubbles, hold and flush.
// Optional stall-cycle counter enabled by defining ID_EX_STALL_CNT_EN.
module id_ex_stage #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [2:0]   in_rs1,
  input  logic [2:0]   in_rs2,
  input  logic         in_use_rs1,
  input  logic         in_use_rs2,
  input  logic [2:0]   in_rd,
  input  logic         in_reg_write,
  input  logic         in_mem_read,
  input  logic [3:0]   in_alu_op,
  input  logic [N-1:0] in_imm,
  output logic [2:0]   rf_addr1,
  output logic [2:0]   rf_addr2,
  output logic         rf_read_en,
  input  logic [N-1:0] rf_data1,
  input  logic [N-1:0] rf_data2,
  input  logic         wb_en,
  input  logic [2:0]   wb_addr,
  input  logic [N-1:0] wb_data,
  input  logic         ex_ready,
  input  logic         flush,
  output logic         id_stall,
`ifdef ID_EX_STALL_CNT_EN
  output logic [15:0]  stall_count,
`endif
  output logic         ex_valid,
  output logic [2:0]   ex_rd,
  output logic         ex_reg_write,
  output logic         ex_mem_read,
  output logic [3:0]   ex_alu_op,
  output logic [N-1:0] ex_imm,
  output logic [N-1:0] ex_op1,
  output logic [N-1:0] ex_op2
);

  logic [N-1:0] op1;
  logic [N-1:0] op2;
  logic         rs1_dep;
  logic         rs2_dep;
  logic         hazard;

  assign rf_addr1   = in_rs1;
  assign rf_addr2   = in_rs2;
  assign rf_read_en = in_valid;

  // Same-cycle writeback wins over the register file read; r0 is an ordinary register.
  assign op1 = (wb_en && (wb_addr == in_rs1)) ? wb_data : rf_data1;
  assign op2 = (wb_en && (wb_addr == in_rs2)) ? wb_data : rf_data2;

  assign rs1_dep  = in_use_rs1 && (in_rs1 == ex_rd);
  assign rs2_dep  = in_use_rs2 && (in_rs2 == ex_rd);
  assign hazard   = in_valid && ex_valid && ex_mem_read && ex_reg_write && (rs1_dep || rs2_dep);
  assign id_stall = !flush && (!ex_ready || hazard);

  // Flush and bubble clear the control bits too, so a dead slot never writes or loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_alu_op    <= '0;
      ex_imm       <= '0;
      ex_op1       <= '0;
      ex_op2       <= '0;
    end else if (flush) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
    end else if (!ex_ready) begin
      ex_valid     <= ex_valid;
    end else if (hazard) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
    end else begin
      ex_valid     <= in_valid;
      ex_rd        <= in_rd;
      ex_reg_write <= in_valid && in_reg_write;
      ex_mem_read  <= in_valid && in_mem_read;
      ex_alu_op    <= in_alu_op;
      ex_imm       <= in_imm;
      ex_op1       <= op1;
      ex_op2       <= op2;
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  // Saturating count of stalled edges; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (id_stall && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: reference model feeds a scoreboard queue of expected latch states.
// Define ID_EX_STALL_CNT_EN to also exercise the stall counter and its saturation.
module tb_id_ex_stage;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid, in_use_rs1, in_use_rs2, in_reg_write, in_mem_read;
  logic [2:0]   in_rs1, in_rs2, in_rd;
  logic [3:0]   in_alu_op;
  logic [N-1:0] in_imm, rf_data1, rf_data2, wb_data;
  logic         wb_en, ex_ready, flush;
  logic [2:0]   wb_addr;
  logic [2:0]   rf_addr1, rf_addr2;
  logic         rf_read_en, id_stall;
  logic         ex_valid, ex_reg_write, ex_mem_read;
  logic [2:0]   ex_rd;
  logic [3:0]   ex_alu_op;
  logic [N-1:0] ex_imm, ex_op1, ex_op2;
`ifdef ID_EX_STALL_CNT_EN
  logic [15:0]  stall_count;
`endif

  always #5 clk = ~clk;

  id_ex_stage #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
    .in_alu_op(in_alu_op), .in_imm(in_imm),
    .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_read_en(rf_read_en),
    .rf_data1(rf_data1), .rf_data2(rf_data2),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_ready(ex_ready), .flush(flush), .id_stall(id_stall),
`ifdef ID_EX_STALL_CNT_EN
    .stall_count(stall_count),
`endif
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_alu_op(ex_alu_op), .ex_imm(ex_imm),
    .ex_op1(ex_op1), .ex_op2(ex_op2)
  );

  typedef struct {
    logic        valid;
    logic [2:0]  rd;
    logic        rw;
    logic        mr;
    logic [3:0]  alu;
    logic [15:0] imm;
    logic [15:0] op1;
    logic [15:0] op2;
    logic        known;
    logic [15:0] cnt;
  } exp_t;

  exp_t m;
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m = '{valid: 1'b0, rd: 3'd0, rw: 1'b0, mr: 1'b0, alu: 4'd0, imm: 16'd0,
          op1: 16'd0, op2: 16'd0, known: 1'b1, cnt: 16'd0};
    sb_q.delete();
  endtask

  task automatic set_idle();
    in_valid = 0; in_use_rs1 = 0; in_use_rs2 = 0; in_reg_write = 0; in_mem_read = 0;
    in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_alu_op = 0; in_imm = 0;
    rf_data1 = 0; rf_data2 = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    ex_ready = 1; flush = 0;
  endtask

  task automatic set_random();
    in_valid = 1'($urandom); in_use_rs1 = 1'($urandom); in_use_rs2 = 1'($urandom);
    in_reg_write = 1'($urandom); in_mem_read = 1'($urandom);
    in_rs1 = 3'($urandom); in_rs2 = 3'($urandom); in_rd = 3'($urandom);
    in_alu_op = 4'($urandom); in_imm = 16'($urandom);
    rf_data1 = 16'($urandom); rf_data2 = 16'($urandom);
    wb_en = 1'($urandom); wb_addr = 3'($urandom); wb_data = 16'($urandom);
    ex_ready = ($urandom_range(0, 3) != 0); flush = ($urandom_range(0, 5) == 0);
  endtask

  // Checks combinational outputs against the model and pushes the expected next latch state.
  task automatic applyStimulus();
    exp_t        nx;
    logic        hz, stall;
    logic [15:0] b1, b2;
    b1 = (wb_en && wb_addr == in_rs1) ? wb_data : rf_data1;
    b2 = (wb_en && wb_addr == in_rs2) ? wb_data : rf_data2;
    hz = in_valid && m.valid && m.mr && m.rw &&
         ((in_use_rs1 && in_rs1 == m.rd) || (in_use_rs2 && in_rs2 == m.rd));
    stall = !flush && (!ex_ready || hz);
    chk("id_stall", 16'(id_stall), 16'(stall));
    chk("rf_addr1", 16'(rf_addr1), 16'(in_rs1));
    chk("rf_addr2", 16'(rf_addr2), 16'(in_rs2));
    chk("rf_read_en", 16'(rf_read_en), 16'(in_valid));
    nx = m;
    if (flush) begin
      nx.valid = 0; nx.rw = 0; nx.mr = 0; nx.known = 0;
    end else if (!ex_ready) begin
      nx = m;
    end else if (hz) begin
      nx.valid = 0; nx.rw = 0; nx.mr = 0; nx.known = 0;
    end else begin
      nx.valid = in_valid; nx.rd = in_rd; nx.rw = in_valid && in_reg_write;
      nx.mr = in_valid && in_mem_read; nx.alu = in_alu_op; nx.imm = in_imm;
      nx.op1 = b1; nx.op2 = b2; nx.known = 1;
    end
    if (stall && m.cnt != 16'hFFFF) nx.cnt = m.cnt + 16'd1;
    m = nx;
    sb_q.push_back(nx);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboard_empty: observed 0 entries expected 1");
      return;
    end
    e = sb_q.pop_front();
    chk("ex_valid", 16'(ex_valid), 16'(e.valid));
    chk("ex_reg_write", 16'(ex_reg_write), 16'(e.rw));
    chk("ex_mem_read", 16'(ex_mem_read), 16'(e.mr));
    if (e.known) begin
      chk("ex_rd", 16'(ex_rd), 16'(e.rd));
      chk("ex_alu_op", 16'(ex_alu_op), 16'(e.alu));
      chk("ex_imm", ex_imm, e.imm);
      chk("ex_op1", ex_op1, e.op1);
      chk("ex_op2", ex_op2, e.op2);
    end
`ifdef ID_EX_STALL_CNT_EN
    chk("stall_count", stall_count, e.cnt);
`endif
  endtask

  task automatic check_reset_state();
    chk("rst_ex_valid", 16'(ex_valid), 16'd0);
    chk("rst_ex_rd", 16'(ex_rd), 16'd0);
    chk("rst_ex_reg_write", 16'(ex_reg_write), 16'd0);
    chk("rst_ex_mem_read", 16'(ex_mem_read), 16'd0);
    chk("rst_ex_alu_op", 16'(ex_alu_op), 16'd0);
    chk("rst_ex_imm", ex_imm, 16'd0);
    chk("rst_ex_op1", ex_op1, 16'd0);
    chk("rst_ex_op2", ex_op2, 16'd0);
    chk("rst_id_stall", 16'(id_stall), 16'(!flush && !ex_ready));
`ifdef ID_EX_STALL_CNT_EN
    chk("rst_stall_count", stall_count, 16'd0);
`endif
  endtask

  // Inputs are set at the falling edge; one call covers one rising edge.
  task automatic do_step();
    #1;
    applyStimulus();
    @(posedge clk);
    #1;
    checkOutput();
    @(negedge clk);
  endtask

  task automatic drive_load(input logic [2:0] rd);
    set_idle();
    in_valid = 1; in_reg_write = 1; in_mem_read = 1; in_rd = rd;
    in_rs1 = 3'd7; in_rs2 = 3'd7; in_use_rs1 = 1; in_alu_op = 4'd1; in_imm = 16'h0010;
    rf_data1 = 16'h1000; rf_data2 = 16'h2000;
  endtask

  task automatic drive_user(input logic [2:0] rs1, input logic [2:0] rs2,
                            input logic use1, input logic use2);
    set_idle();
    in_valid = 1; in_reg_write = 1; in_rd = 3'd4; in_alu_op = 4'd2; in_imm = 16'h0044;
    in_rs1 = rs1; in_rs2 = rs2; in_use_rs1 = use1; in_use_rs2 = use2;
    rf_data1 = 16'hA1A1; rf_data2 = 16'hB2B2;
  endtask

  initial begin
    // Asynchronous reset with random inputs
    set_random();
    rst = 1;
    #1;
    check_reset_state();
    @(negedge clk);
    set_random();
    #1;
    check_reset_state();
    @(negedge clk);
    set_idle();
    rst = 0;
    model_reset();

    // First capture after reset
    in_valid = 1; in_reg_write = 1; in_rd = 3'd5; in_rs1 = 3'd1; in_rs2 = 3'd6;
    rf_data1 = 16'h1234; rf_data2 = 16'h00FF; in_alu_op = 4'd3; in_imm = 16'hABCD;
    do_step();
    chk("first_op1_const", ex_op1, 16'h1234);

    // Writeback bypass hit, miss, and r0
    set_idle();
    in_valid = 1; in_rs1 = 3'd3; rf_data1 = 16'h0001; in_rs2 = 3'd2; rf_data2 = 16'h0202;
    wb_en = 1; wb_addr = 3'd3; wb_data = 16'hBEEF;
    do_step();
    chk("bypass_hit_const", ex_op1, 16'hBEEF);
    in_valid = 1; in_rs1 = 3'd3; rf_data1 = 16'h0001; wb_en = 1; wb_addr = 3'd4; wb_data = 16'hBEEF;
    do_step();
    chk("bypass_miss_const", ex_op1, 16'h0001);
    in_valid = 1; in_rs1 = 3'd0; in_rs2 = 3'd0; wb_addr = 3'd0; wb_data = 16'h5A5A;
    do_step();

    // Load-use on rs2: one bubble then capture
    drive_load(3'd2);
    do_step();
    drive_user(3'd5, 3'd2, 1'b0, 1'b1);
    do_step();
    do_step();
    // Load followed by non-user of r2
    drive_load(3'd2);
    do_step();
    drive_user(3'd5, 3'd2, 1'b0, 1'b0);
    do_step();
    // Load-use on rs1
    drive_load(3'd6);
    do_step();
    drive_user(3'd6, 3'd1, 1'b1, 1'b0);
    do_step();
    do_step();

    // Downstream hold for three cycles with changing ID inputs
    set_idle();
    in_valid = 1; in_reg_write = 1; in_rd = 3'd1; rf_data1 = 16'h7777; rf_data2 = 16'h8888;
    do_step();
    for (int i = 0; i < 3; i++) begin
      set_random();
      ex_ready = 0; flush = 0;
      do_step();
    end
    set_idle();
    in_valid = 1; in_rd = 3'd3; rf_data1 = 16'h3333;
    do_step();

    // Hold coincident with hazard, then bubble, then capture
    drive_load(3'd5);
    do_step();
    drive_user(3'd5, 3'd5, 1'b1, 1'b1);
    ex_ready = 0;
    do_step();
    ex_ready = 1;
    do_step();
    do_step();

    // Flush coincident with hazard and hold
    drive_load(3'd2);
    do_step();
    drive_user(3'd2, 3'd2, 1'b1, 1'b1);
    flush = 1; ex_ready = 0;
    do_step();
    flush = 0; ex_ready = 1;
    do_step();

    // Reset asserted mid-stall, then normal capture
    drive_load(3'd3);
    do_step();
    drive_user(3'd3, 3'd0, 1'b1, 1'b0);
    ex_ready = 0;
    do_step();
    rst = 1;
    #1;
    check_reset_state();
    @(posedge clk);
    #1;
    check_reset_state();
    @(negedge clk);
    rst = 0;
    model_reset();
    drive_user(3'd3, 3'd0, 1'b1, 1'b0);
    do_step();

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      set_random();
      do_step();
    end

`ifdef ID_EX_STALL_CNT_EN
    // Counter saturation under a long hold
    set_idle();
    ex_ready = 0;
    repeat (65540) @(posedge clk);
    @(negedge clk);
    m.cnt = 16'hFFFF;
    chk("stall_count_sat", stall_count, 16'hFFFF);
    do_step();
    do_step();
    chk("stall_count_stays", stall_count, 16'hFFFF);
    ex_ready = 1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
